// File: rtl/enemy_pkg.sv
// Shared types and constants for the turtle enemy scheduler.
// ENEMY_SHELL_KILL_EN (optional) lets sliding shells free nearby walkers.
package enemy_pkg;

    typedef enum logic [1:0] {
        SlotFree  = 2'd0,
        SlotWalk  = 2'd1,
        SlotShell = 2'd2,
        SlotSlide = 2'd3
    } slot_st_e;

    typedef enum logic {
        FsmIdle,
        FsmSweep
    } fsm_e;

    localparam slot_st_e SlotFreeEnc = SlotFree;
    localparam int unsigned SlotIdxW = 3;
    localparam int unsigned KillDist = 16;

    // LSB position of a slot's x field inside the packed slot_x bus
    function automatic int unsigned slot_x_lsb(int unsigned slot, int unsigned x_w);
        return slot * x_w;
    endfunction

endpackage

// File: rtl/enemy_slot_alloc.sv
// Lowest-index free-slot priority encoder used to place spawn requests.
module enemy_slot_alloc
    import enemy_pkg::*;
#(
    parameter int unsigned N_SLOTS = 4
) (
    input  logic [N_SLOTS-1:0]  free_i,
    output logic                found_o,
    output logic [SlotIdxW-1:0] slot_o
);

    always_comb begin
        found_o = 1'b0;
        slot_o  = '0;
        for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                found_o = 1'b1;
                slot_o  = SlotIdxW'(i);
            end
        end
    end

endmodule

// File: rtl/enemy_scheduler.sv
// Walks all enemy slots once per frame tick on a shared update engine and grants spawns.
// Define ENEMY_SHELL_KILL_EN to let a moving shell free walkers within KillDist pixels.
module enemy_scheduler
    import enemy_pkg::*;
#(
    parameter int unsigned N_SLOTS    = 4,
    parameter int unsigned X_W        = 11,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 1279,
    parameter int unsigned WALK_STEP  = 1,
    parameter int unsigned SLIDE_STEP = 4,
    parameter int unsigned WALK_DIV   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   tick,
    input  logic                   spawn_req,
    input  logic [X_W-1:0]         spawn_x,
    output logic                   spawn_ack,
    output logic [2:0]             spawn_slot,
    input  logic                   stomp_valid,
    input  logic [2:0]             stomp_slot,
    output logic [N_SLOTS-1:0]     slot_active,
    output logic [N_SLOTS*X_W-1:0] slot_x,
    output logic [N_SLOTS-1:0]     slot_oriental,
    output logic [N_SLOTS-1:0]     collapsion_impulse,
    output logic [N_SLOTS-1:0]     press_impulse,
    output logic                   walk_anim,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned XEW   = X_W + 1;
    localparam int unsigned AnimW = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
    localparam logic [X_W:0] XMinE    = XEW'(X_MIN);
    localparam logic [X_W:0] XMaxE    = XEW'(X_MAX);
    localparam logic [X_W:0] XMinP1   = XEW'(X_MIN + 1);
    localparam logic [X_W:0] WStepE   = XEW'(WALK_STEP);
    localparam logic [X_W:0] SStepE   = XEW'(SLIDE_STEP);
    localparam logic [SlotIdxW:0] StompLim = (SlotIdxW + 1)'(N_SLOTS);

    fsm_e                         fsm_q, fsm_d;
    logic [SlotIdxW-1:0]          idx_q, idx_d;
    slot_st_e [N_SLOTS-1:0]       st_q, st_d;
    logic [N_SLOTS-1:0][X_W-1:0]  x_q, x_d;
    logic [N_SLOTS-1:0]           ori_q, ori_d, coll_q, coll_d;
    logic [N_SLOTS-1:0]           press_q, press_d, pend_q, pend_d;
    logic                         busy_q, busy_d, ovr_q, ovr_d;
    logic                         ack_q, ack_d, anim_q, anim_d;
    logic [SlotIdxW-1:0]          ack_slot_q, ack_slot_d;
    logic [AnimW-1:0]             anim_cnt_q, anim_cnt_d;

    logic [X_W:0]                 xe, xn, spawn_e;
    logic [X_W-1:0]               spawn_cl;
    logic [N_SLOTS-1:0]           free_mask;
    logic                         free_found;
    logic [SlotIdxW-1:0]          free_slot;
`ifdef ENEMY_SHELL_KILL_EN
    logic                         slide_mv;
    logic [X_W:0]                 slide_x, wx, dist;
`endif

    enemy_slot_alloc #(
        .N_SLOTS(N_SLOTS)
    ) u_alloc (
        .free_i (free_mask),
        .found_o(free_found),
        .slot_o (free_slot)
    );

    always_comb begin
        spawn_e = {1'b0, spawn_x};
        if (spawn_e + XEW'(1) < XMinP1) begin
            spawn_cl = XMinE[X_W-1:0];
        end else if (spawn_e > XMaxE) begin
            spawn_cl = XMaxE[X_W-1:0];
        end else begin
            spawn_cl = spawn_x;
        end
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            free_mask[i]   = (st_q[i] == SlotFreeEnc);
            slot_active[i] = (st_q[i] != SlotFreeEnc);
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        idx_d      = idx_q;
        st_d       = st_q;
        x_d        = x_q;
        ori_d      = ori_q;
        coll_d     = coll_q;
        press_d    = press_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;
        ack_d      = 1'b0;
        ack_slot_d = ack_slot_q;
        anim_d     = anim_q;
        anim_cnt_d = anim_cnt_q;
        xe         = '0;
        xn         = '0;
`ifdef ENEMY_SHELL_KILL_EN
        slide_mv   = 1'b0;
        slide_x    = '0;
        wx         = '0;
        dist       = '0;
`endif
        unique case (fsm_q)
            FsmIdle: begin
                // A tick outranks a spawn; the held request is granted on the next idle cycle
                if (tick) begin
                    fsm_d  = FsmSweep;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (anim_cnt_q == AnimW'(WALK_DIV - 1)) begin
                        anim_cnt_d = '0;
                        anim_d     = ~anim_q;
                    end else begin
                        anim_cnt_d = anim_cnt_q + AnimW'(1);
                    end
                end else if (spawn_req && !ack_q && free_found) begin
                    ack_d      = 1'b1;
                    ack_slot_d = free_slot;
                    for (int i = 0; i < int'(N_SLOTS); i++) begin
                        if (free_slot == SlotIdxW'(i)) begin
                            st_d[i]   = SlotWalk;
                            x_d[i]    = spawn_cl;
                            ori_d[i]  = 1'b1;
                            pend_d[i] = 1'b0;
                        end
                    end
                end
            end
            FsmSweep: begin
                if (tick) ovr_d = 1'b1;
                for (int i = 0; i < int'(N_SLOTS); i++) begin
                    if (idx_q == SlotIdxW'(i)) begin
                        xe        = {1'b0, x_q[i]};
                        pend_d[i] = 1'b0;
                        if (pend_q[i]) begin
                            if (st_q[i] != SlotFree) press_d[i] = ~press_q[i];
                            case (st_q[i])
                                SlotWalk:  st_d[i] = SlotShell;
                                SlotShell: st_d[i] = SlotSlide;
                                SlotSlide: st_d[i] = SlotShell;
                                default:   st_d[i] = st_q[i];
                            endcase
                        end else if (st_q[i] == SlotWalk) begin
                            if (ori_q[i]) begin
                                if (xe < XMinE + WStepE) begin
                                    x_d[i]    = XMinE[X_W-1:0];
                                    ori_d[i]  = 1'b0;
                                    coll_d[i] = ~coll_q[i];
                                end else begin
                                    xn     = xe - WStepE;
                                    x_d[i] = xn[X_W-1:0];
                                end
                            end else begin
                                xn = xe + WStepE;
                                if (xn > XMaxE) begin
                                    x_d[i]    = XMaxE[X_W-1:0];
                                    ori_d[i]  = 1'b1;
                                    coll_d[i] = ~coll_q[i];
                                end else begin
                                    x_d[i] = xn[X_W-1:0];
                                end
                            end
                        end else if (st_q[i] == SlotSlide) begin
                            xn = ori_q[i] ? xe - SStepE : xe + SStepE;
                            if ((ori_q[i] && (xe < XMinE + SStepE)) || (!ori_q[i] && (xn > XMaxE))) begin
                                st_d[i] = SlotFree;
                            end else begin
                                x_d[i] = xn[X_W-1:0];
`ifdef ENEMY_SHELL_KILL_EN
                                slide_mv = 1'b1;
                                slide_x  = xn;
`endif
                            end
                        end
                    end
                end
`ifdef ENEMY_SHELL_KILL_EN
                if (slide_mv) begin
                    for (int j = 0; j < int'(N_SLOTS); j++) begin
                        if (st_q[j] == SlotWalk) begin
                            wx   = {1'b0, x_q[j]};
                            dist = (wx > slide_x) ? wx - slide_x : slide_x - wx;
                            if (dist < XEW'(KillDist)) st_d[j] = SlotFree;
                        end
                    end
                end
`endif
                if (idx_q == SlotIdxW'(N_SLOTS - 1)) begin
                    fsm_d  = FsmIdle;
                    busy_d = 1'b0;
                end else begin
                    idx_d = idx_q + SlotIdxW'(1);
                end
            end
            default: fsm_d = FsmIdle;
        endcase
        // Set after the visit clear so a stomp landing on its own update edge survives
        if (stomp_valid && ({1'b0, stomp_slot} < StompLim)) begin
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                if (stomp_slot == SlotIdxW'(i)) pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            fsm_q      <= FsmIdle;
            idx_q      <= '0;
            for (int i = 0; i < int'(N_SLOTS); i++) st_q[i] <= SlotFree;
            x_q        <= '0;
            ori_q      <= '1;
            coll_q     <= '0;
            press_q    <= '0;
            pend_q     <= '0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ack_q      <= 1'b0;
            ack_slot_q <= '0;
            anim_q     <= 1'b0;
            anim_cnt_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            idx_q      <= idx_d;
            st_q       <= st_d;
            x_q        <= x_d;
            ori_q      <= ori_d;
            coll_q     <= coll_d;
            press_q    <= press_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            ack_q      <= ack_d;
            ack_slot_q <= ack_slot_d;
            anim_q     <= anim_d;
            anim_cnt_q <= anim_cnt_d;
        end
    end

    assign spawn_ack          = ack_q;
    assign spawn_slot         = ack_slot_q;
    assign slot_x             = x_q;
    assign slot_oriental      = ori_q;
    assign collapsion_impulse = coll_q;
    assign press_impulse      = press_q;
    assign walk_anim          = anim_q;
    assign busy               = busy_q;
    assign overrun            = ovr_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Self-checking bench for enemy_scheduler against a per-sweep behavioural model.
// Honours ENEMY_SHELL_KILL_EN when the design is built with it.
module tb_enemy_scheduler;

    localparam int N = 4, XW = 11, XMIN = 0, XMAX = 1279;
    localparam int WS = 1, SS = 4, WDIV = 8;
    localparam int MF = 0, MW = 1, MSH = 2, MSL = 3;

    logic          clk = 1'b0;
    logic          rstn, tick, spawn_req, stomp_valid;
    logic [XW-1:0] spawn_x;
    logic [2:0]    stomp_slot, spawn_slot;
    logic          spawn_ack, walk_anim, busy, overrun;
    logic [N-1:0]  slot_active, slot_oriental, collapsion_impulse, press_impulse;
    logic [N*XW-1:0] slot_x;

    int checks = 0, errors = 0, ack_seen = 0;

    int m_st[N], m_x[N];
    bit m_ori[N], m_coll[N], m_press[N], m_pend[N];
    bit m_anim;
    int m_tcnt;

    enemy_scheduler u_dut (
        .clk(clk), .rstn(rstn), .tick(tick), .spawn_req(spawn_req), .spawn_x(spawn_x),
        .spawn_ack(spawn_ack), .spawn_slot(spawn_slot), .stomp_valid(stomp_valid),
        .stomp_slot(stomp_slot), .slot_active(slot_active), .slot_x(slot_x),
        .slot_oriental(slot_oriental), .collapsion_impulse(collapsion_impulse),
        .press_impulse(press_impulse), .walk_anim(walk_anim), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (spawn_ack === 1'b1) ack_seen++;

    function automatic int dut_x(int i);
        return int'(slot_x[i*XW +: XW]);
    endfunction

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = MF; m_x[i] = 0; m_ori[i] = 1; m_coll[i] = 0; m_press[i] = 0; m_pend[i] = 0;
        end
        m_anim = 0; m_tcnt = 0;
    endfunction

    function automatic int m_spawn(int x);
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == MF) begin
                m_st[i] = MW; m_ori[i] = 1; m_pend[i] = 0;
                m_x[i] = (x < XMIN) ? XMIN : ((x > XMAX) ? XMAX : x);
                return i;
            end
        end
        return -1;
    endfunction

    function automatic void m_stomp(int s);
        if (s < N) m_pend[s] = 1;
    endfunction

    function automatic void m_sweep();
        int nx, d;
        m_tcnt++;
        if (m_tcnt == WDIV) begin m_tcnt = 0; m_anim = ~m_anim; end
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) begin
                m_pend[i] = 0;
                if (m_st[i] != MF) m_press[i] = ~m_press[i];
                if (m_st[i] == MW) m_st[i] = MSH;
                else if (m_st[i] == MSH) m_st[i] = MSL;
                else if (m_st[i] == MSL) m_st[i] = MSH;
            end else if (m_st[i] == MW) begin
                nx = m_ori[i] ? m_x[i] - WS : m_x[i] + WS;
                if (nx < XMIN || nx > XMAX) begin
                    m_x[i] = (nx < XMIN) ? XMIN : XMAX;
                    m_ori[i] = ~m_ori[i]; m_coll[i] = ~m_coll[i];
                end else m_x[i] = nx;
            end else if (m_st[i] == MSL) begin
                nx = m_ori[i] ? m_x[i] - SS : m_x[i] + SS;
                if (nx < XMIN || nx > XMAX) m_st[i] = MF;
                else begin
                    m_x[i] = nx;
`ifdef ENEMY_SHELL_KILL_EN
                    for (int j = 0; j < N; j++) begin
                        d = m_x[j] - nx;
                        if (d < 0) d = -d;
                        if (m_st[j] == MW && d < 16) m_st[j] = MF;
                    end
`endif
                end
            end
        end
    endfunction

    function automatic bit m_has_free();
        for (int i = 0; i < N; i++) if (m_st[i] == MF) return 1;
        return 0;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic apply_reset();
        rstn = 1; tick = 0; spawn_req = 0; stomp_valid = 0; spawn_x = '0; stomp_slot = '0;
        @(negedge clk); @(negedge clk);
        rstn = 0;
        m_reset();
    endtask

    task automatic do_tick(output int bc);
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
        bc = 0;
        while (busy === 1'b1 && bc < 50) begin bc++; @(negedge clk); end
    endtask

    task automatic do_spawn(input int x, output int slot, output int lat);
        @(negedge clk); spawn_req = 1; spawn_x = XW'(x);
        lat = 0;
        do begin @(negedge clk); lat++; end while (spawn_ack !== 1'b1 && lat < 40);
        slot = (spawn_ack === 1'b1) ? int'(spawn_slot) : -1;
        @(posedge clk); #1 spawn_req = 0;
    endtask

    task automatic do_stomp(input int s);
        @(negedge clk); stomp_valid = 1; stomp_slot = 3'(s);
        @(negedge clk); stomp_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (slot_active !== '0 || slot_oriental !== '1 || slot_x !== '0) begin
            errors++; $display("FAIL reset_slots: act=%b ori=%b x=%h required act=0 ori=1111 x=0",
                               slot_active, slot_oriental, slot_x);
        end
        checks++;
        if ({collapsion_impulse, press_impulse, walk_anim, busy, overrun, spawn_ack} !== '0) begin
            errors++; $display("FAIL reset_flags: coll=%b press=%b anim=%b busy=%b ovr=%b ack=%b required all 0",
                               collapsion_impulse, press_impulse, walk_anim, busy, overrun, spawn_ack);
        end
    endtask

    task automatic test_spawn();
        int slot, lat, ms;
        apply_reset();
        do_spawn(100, slot, lat);
        ms = m_spawn(100);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL spawn_latency: got %0d required 1", lat); end
        checks++;
        if (slot !== ms) begin errors++; $display("FAIL spawn_slot: got %0d required %0d", slot, ms); end
        checks++;
        if (slot_active !== 4'b0001 || slot_oriental[0] !== 1'b1 || dut_x(0) !== 100) begin
            errors++; $display("FAIL spawn_state: act=%b ori=%b x=%0d required 0001 1 100",
                               slot_active, slot_oriental[0], dut_x(0));
        end
        do_spawn(2000, slot, lat);
        ms = m_spawn(2000);
        checks++;
        if (slot !== ms || dut_x(1) !== m_x[1]) begin
            errors++; $display("FAIL spawn_clamp: slot=%0d x=%0d required %0d %0d", slot, dut_x(1), ms, m_x[1]);
        end
    endtask

    task automatic test_walk();
        int slot, lat, bc, ms;
        apply_reset();
        do_spawn(2, slot, lat);
        ms = m_spawn(2);
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
        checks++;
        if (busy !== 1'b1 || dut_x(0) !== 2) begin
            errors++; $display("FAIL tick_edge: busy=%b x=%0d required 1 2", busy, dut_x(0));
        end
        @(negedge clk);
        checks++;
        if (dut_x(0) !== 1) begin errors++; $display("FAIL slot0_edge: x=%0d required 1", dut_x(0)); end
        bc = 0;
        while (busy === 1'b1 && bc < 50) begin bc++; @(negedge clk); end
        m_sweep();
        for (int t = 0; t < 2; t++) begin
            do_tick(bc);
            m_sweep();
            checks++;
            if (bc !== N) begin errors++; $display("FAIL busy_len: got %0d required %0d", bc, N); end
        end
        checks++;
        if (dut_x(0) !== m_x[0] || slot_oriental[0] !== m_ori[0] || collapsion_impulse[0] !== m_coll[0]) begin
            errors++; $display("FAIL wall_clamp: x=%0d ori=%b coll=%b required %0d %b %b (slot %0d)",
                               dut_x(0), slot_oriental[0], collapsion_impulse[0], m_x[0], m_ori[0], m_coll[0], ms);
        end
    endtask

    task automatic test_stomp();
        int slot, lat, bc, ms, n;
        apply_reset();
        do_spawn(600, slot, lat); ms = m_spawn(600);
        do_spawn(0, slot, lat);   ms = m_spawn(0);
        do_tick(bc); m_sweep();
        do_stomp(1); m_stomp(1);
        do_tick(bc); m_sweep();
        checks++;
        if (slot_active[1] !== 1'b1 || press_impulse[1] !== m_press[1] || dut_x(1) !== m_x[1]) begin
            errors++; $display("FAIL stomp_shell: act=%b press=%b x=%0d required 1 %b %0d",
                               slot_active[1], press_impulse[1], dut_x(1), m_press[1], m_x[1]);
        end
        do_stomp(1); m_stomp(1);
        do_tick(bc); m_sweep();
        checks++;
        if (press_impulse[1] !== m_press[1] || dut_x(1) !== m_x[1]) begin
            errors++; $display("FAIL stomp_slide: press=%b x=%0d required %b %0d",
                               press_impulse[1], dut_x(1), m_press[1], m_x[1]);
        end
        n = 0;
        while (m_st[1] != MF && n < 400) begin
            do_tick(bc); m_sweep(); n++;
            checks++;
            if (slot_active[1] !== (m_st[1] != MF) || (m_st[1] != MF && dut_x(1) !== m_x[1])) begin
                errors++; $display("FAIL slide_out: tick %0d act=%b x=%0d required %b %0d",
                                   n, slot_active[1], dut_x(1), m_st[1] != MF, m_x[1]);
            end
        end
        checks++;
        if (dut_x(0) !== m_x[0] || slot_active[0] !== 1'b1) begin
            errors++; $display("FAIL walker_long: x=%0d act=%b required %0d 1", dut_x(0), slot_active[0], m_x[0]);
        end
    endtask

    task automatic test_stomp_collision();
        int slot, lat, bc, ms;
        apply_reset();
        do_spawn(500, slot, lat); ms = m_spawn(500);
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0; stomp_valid = 1; stomp_slot = 3'd0;
        @(negedge clk); stomp_valid = 0;
        bc = 0;
        while (busy === 1'b1 && bc < 50) begin bc++; @(negedge clk); end
        m_sweep(); m_stomp(0);
        checks++;
        if (dut_x(0) !== m_x[0] || press_impulse[0] !== m_press[0]) begin
            errors++; $display("FAIL stomp_same_edge: x=%0d press=%b required %0d %b",
                               dut_x(0), press_impulse[0], m_x[0], m_press[0]);
        end
        do_tick(bc); m_sweep();
        checks++;
        if (press_impulse[0] !== m_press[0] || dut_x(0) !== m_x[0]) begin
            errors++; $display("FAIL stomp_kept: press=%b x=%0d required %b %0d",
                               press_impulse[0], dut_x(0), m_press[0], m_x[0]);
        end
    endtask

    task automatic test_full();
        int slot, lat, bc, ms, acks0;
        apply_reset();
        do_spawn(600, slot, lat); ms = m_spawn(600);
        do_spawn(600, slot, lat); ms = m_spawn(600);
        do_spawn(10, slot, lat);  ms = m_spawn(10);
        do_spawn(600, slot, lat); ms = m_spawn(600);
        @(negedge clk);
        acks0 = ack_seen;
        spawn_req = 1; spawn_x = 11'd77;
        repeat (10) @(negedge clk);
        checks++;
        if (ack_seen !== acks0) begin errors++; $display("FAIL full_no_ack: acks=%0d required 0", ack_seen - acks0); end
        do_stomp(2); m_stomp(2);
        do_tick(bc); m_sweep();
        do_stomp(2); m_stomp(2);
        while (m_st[2] != MF && bc < 50) begin do_tick(bc); m_sweep(); end
        lat = 0;
        while (spawn_ack !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        ms = m_spawn(77);
        checks++;
        if (spawn_ack !== 1'b1 || int'(spawn_slot) !== ms) begin
            errors++; $display("FAIL full_late_ack: ack=%b slot=%0d required 1 %0d", spawn_ack, spawn_slot, ms);
        end
        @(posedge clk); #1 spawn_req = 0;
        @(negedge clk);
        checks++;
        if (ack_seen - acks0 !== 1 || dut_x(2) !== 77) begin
            errors++; $display("FAIL full_ack_count: acks=%0d x=%0d required 1 77", ack_seen - acks0, dut_x(2));
        end
    endtask

    task automatic test_tick_priority();
        int lat, ms;
        apply_reset();
        @(negedge clk); tick = 1; spawn_req = 1; spawn_x = 11'd300;
        @(negedge clk); tick = 0;
        m_sweep();
        checks++;
        if (busy !== 1'b1 || spawn_ack !== 1'b0) begin
            errors++; $display("FAIL tick_wins: busy=%b ack=%b required 1 0", busy, spawn_ack);
        end
        lat = 0;
        while (spawn_ack !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        ms = m_spawn(300);
        @(posedge clk); #1 spawn_req = 0;
        checks++;
        if (lat !== N + 1 || int'(spawn_slot) !== ms) begin
            errors++; $display("FAIL deferred_spawn: lat=%0d slot=%0d required %0d %0d", lat, spawn_slot, N + 1, ms);
        end
    endtask

    task automatic test_overrun();
        int slot, lat, bc, ms, free_at, acc;
        apply_reset();
        do_spawn(700, slot, lat); ms = m_spawn(700);
        do_tick(bc); m_sweep();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_idle: got %b required 0", overrun); end
        free_at = 0; acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); tick = 1;
            @(negedge clk); tick = 0;
            @(negedge clk);
            if (3 * k >= free_at) begin acc++; free_at = 3 * k + N + 1; m_sweep(); end
        end
        bc = 0;
        while (busy === 1'b1 && bc < 50) begin bc++; @(negedge clk); end
        checks++;
        if (overrun !== 1'b1 || dut_x(0) !== m_x[0]) begin
            errors++; $display("FAIL overrun_set: ovr=%b x=%0d required 1 %0d (accepted %0d)",
                               overrun, dut_x(0), m_x[0], acc);
        end
        do_tick(bc); m_sweep();
        checks++;
        if (bc !== N || overrun !== 1'b1 || dut_x(0) !== m_x[0]) begin
            errors++; $display("FAIL overrun_recover: busy=%0d ovr=%b x=%0d required %0d 1 %0d",
                               bc, overrun, dut_x(0), N, m_x[0]);
        end
    endtask

    task automatic test_reset_mid();
        int slot, lat, ms;
        apply_reset();
        do_spawn(400, slot, lat); ms = m_spawn(400);
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
        @(negedge clk);
        rstn = 1;
        #1;
        checks++;
        if (busy !== 1'b0 || slot_active !== '0) begin
            errors++; $display("FAIL reset_mid: busy=%b act=%b required 0 0000", busy, slot_active);
        end
        @(negedge clk); rstn = 0; m_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || slot_active !== '0) begin
            errors++; $display("FAIL reset_mid_hold: busy=%b act=%b required 0 0000", busy, slot_active);
        end
    endtask

    task automatic test_kill();
        int slot, lat, bc, ms;
        bit exp_alive;
        apply_reset();
        do_spawn(200, slot, lat); ms = m_spawn(200);
        do_spawn(210, slot, lat); ms = m_spawn(210);
        do_stomp(0); m_stomp(0);
        do_tick(bc); m_sweep();
        do_stomp(0); m_stomp(0);
        do_tick(bc); m_sweep();
        do_tick(bc); m_sweep();
`ifdef ENEMY_SHELL_KILL_EN
        exp_alive = 1'b0;
`else
        exp_alive = 1'b1;
`endif
        checks++;
        if (slot_active[1] !== exp_alive || slot_active[1] !== (m_st[1] != MF)) begin
            errors++; $display("FAIL shell_kill: walker act=%b required %b", slot_active[1], exp_alive);
        end
        checks++;
        if (dut_x(0) !== m_x[0]) begin errors++; $display("FAIL shell_pos: x=%0d required %0d", dut_x(0), m_x[0]); end
    endtask

    task automatic test_random();
        int slot, lat, bc, ms, op, s;
        apply_reset();
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 2 && m_has_free()) begin
                s = $urandom_range(0, 2047);
                do_spawn(s, slot, lat); ms = m_spawn(s);
                checks++;
                if (slot !== ms) begin errors++; $display("FAIL rnd_spawn: it %0d slot=%0d required %0d", it, slot, ms); end
            end else if (op >= 3 && op <= 5) begin
                s = $urandom_range(0, 7);
                do_stomp(s); m_stomp(s);
            end else begin
                do_tick(bc); m_sweep();
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (slot_active[i] !== (m_st[i] != MF) || collapsion_impulse[i] !== m_coll[i] ||
                    press_impulse[i] !== m_press[i]) begin
                    errors++; $display("FAIL rnd_flags: it %0d slot %0d act=%b coll=%b press=%b required %b %b %b",
                                       it, i, slot_active[i], collapsion_impulse[i], press_impulse[i],
                                       m_st[i] != MF, m_coll[i], m_press[i]);
                end
                if (m_st[i] != MF) begin
                    checks++;
                    if (dut_x(i) !== m_x[i] || slot_oriental[i] !== m_ori[i]) begin
                        errors++; $display("FAIL rnd_pos: it %0d slot %0d x=%0d ori=%b required %0d %b",
                                           it, i, dut_x(i), slot_oriental[i], m_x[i], m_ori[i]);
                    end
                end
            end
            checks++;
            if (walk_anim !== m_anim) begin errors++; $display("FAIL rnd_anim: it %0d got %b required %b", it, walk_anim, m_anim); end
        end
    endtask

    initial begin
        rstn = 1; tick = 0; spawn_req = 0; stomp_valid = 0; spawn_x = '0; stomp_slot = '0;
        test_reset();
        test_spawn();
        test_walk();
        test_stomp();
        test_stomp_collision();
        test_full();
        test_tick_priority();
        test_overrun();
        test_reset_mid();
        test_kill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
